// File: rtl/regfile_wb.sv
// Integer register file with two combinational read ports, a writeback port and
// a pending-write scoreboard. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] reg_waddr_i,
  input  logic              reg_we_i,
  input  logic [DATA_W-1:0] reg_wdata_i,
  input  logic [ADDR_W-1:0] rs1_raddr_i,
  input  logic              rs1_re_i,
  output logic [DATA_W-1:0] rs1_rdata_o,
  input  logic [ADDR_W-1:0] rs2_raddr_i,
  input  logic              rs2_re_i,
  output logic [DATA_W-1:0] rs2_rdata_o,
  input  logic              pend_set_i,
  input  logic [ADDR_W-1:0] pend_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr_en;
  logic              set_en;

  logic [ADDR_W-1:0] raddr [2];
  logic              re    [2];
  logic [DATA_W-1:0] rdata [2];
  logic              busy  [2];

  assign wr_en  = reg_we_i   && (reg_waddr_i != '0);
  assign set_en = pend_set_i && (pend_addr_i != '0);

  // Clear is applied before set so a same-address set wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_en)  pend_nxt[reg_waddr_i] = 1'b0;
    if (set_en) pend_nxt[pend_addr_i] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (wr_en) regs[reg_waddr_i] <= reg_wdata_i;
      pend <= pend_nxt;
    end
  end

  assign raddr[0] = rs1_raddr_i;
  assign raddr[1] = rs2_raddr_i;
  assign re[0]    = rs1_re_i;
  assign re[1]    = rs2_re_i;

  // Outputs are forced quiet during reset so the bypass/hit paths cannot leak.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      logic active;
      logic hit;
      rdata[p] = '0;
      busy[p]  = 1'b0;
      active   = !rst_i && re[p] && (raddr[p] != '0);
      hit      = wr_en && (reg_waddr_i == raddr[p]);
      if (active) begin
`ifdef REGFILE_BYPASS_EN
        rdata[p] = hit ? reg_wdata_i : regs[raddr[p]];
        busy[p]  = pend[raddr[p]] && !hit;
`else
        rdata[p] = regs[raddr[p]];
        busy[p]  = pend[raddr[p]] || hit;
`endif
      end
    end
  end

  assign rs1_rdata_o = rdata[0];
  assign rs2_rdata_o = rdata[1];
  assign rs1_busy_o  = busy[0];
  assign rs2_busy_o  = busy[1];

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb; expectations follow the build's
// REGFILE_BYPASS_EN setting.
module tb_regfile_wb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [4:0]  rs1_raddr_i = '0;
  logic        rs1_re_i = 1'b0;
  logic [31:0] rs1_rdata_o;
  logic [4:0]  rs2_raddr_i = '0;
  logic        rs2_re_i = 1'b0;
  logic [31:0] rs2_rdata_o;
  logic        pend_set_i = 1'b0;
  logic [4:0]  pend_addr_i = '0;
  logic        rs1_busy_o;
  logic        rs2_busy_o;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .rs1_raddr_i(rs1_raddr_i), .rs1_re_i(rs1_re_i), .rs1_rdata_o(rs1_rdata_o),
    .rs2_raddr_i(rs2_raddr_i), .rs2_re_i(rs2_re_i), .rs2_rdata_o(rs2_rdata_o),
    .pend_set_i(pend_set_i), .pend_addr_i(pend_addr_i),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1 rst_i = 1'b1;
    rs1_re_i = 1'b1; rs1_raddr_i = 5'd5;
    #1;
    chk("reset_rdata", rs1_rdata_o, 32'h0);
    chk("reset_busy", {31'b0, rs1_busy_o}, 32'h0);
    tick();
    rst_i = 1'b0;

    // x5 write, then an asynchronous reset pulse between edges
    reg_we_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'hDEADBEEF;
    tick();
    reg_we_i = 1'b0;
    #1;
    chk("x5_written", rs1_rdata_o, 32'hDEADBEEF);
    rst_i = 1'b1;
    #1;
    chk("x5_async_reset", rs1_rdata_o, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("x5_after_reset", rs1_rdata_o, 32'h0);

    // x0 write and pend set ignored
    tick();
    reg_we_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 32'h12345678;
    pend_set_i = 1'b1; pend_addr_i = 5'd0;
    rs1_raddr_i = 5'd0;
    #1;
    chk("x0_same_cycle_busy", {31'b0, rs1_busy_o}, 32'h0);
    tick();
    reg_we_i = 1'b0; pend_set_i = 1'b0;
    #1;
    chk("x0_read", rs1_rdata_o, 32'h0);
    chk("x0_busy", {31'b0, rs1_busy_o}, 32'h0);

    // basic write/read on both ports
    reg_we_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'hA5A5A5A5;
    tick();
    reg_we_i = 1'b0;
    rs1_raddr_i = 5'd3; rs2_raddr_i = 5'd3; rs2_re_i = 1'b1;
    #1;
    chk("x3_rs1", rs1_rdata_o, 32'hA5A5A5A5);
    chk("x3_rs2", rs2_rdata_o, 32'hA5A5A5A5);
    rs2_re_i = 1'b0;
    #1;
    chk("x3_rs2_disabled", rs2_rdata_o, 32'h0);
    chk("x3_rs1_still", rs1_rdata_o, 32'hA5A5A5A5);

    // scoreboard lifecycle on x7
    tick();
    pend_set_i = 1'b1; pend_addr_i = 5'd7; rs1_raddr_i = 5'd7;
    #1;
    chk("x7_busy_c0", {31'b0, rs1_busy_o}, 32'h0);
    tick();
    pend_set_i = 1'b0;
    #1;
    chk("x7_busy_c1", {31'b0, rs1_busy_o}, 32'h1);
    rs1_re_i = 1'b0;
    #1;
    chk("x7_busy_re0", {31'b0, rs1_busy_o}, 32'h0);
    rs1_re_i = 1'b1;
    tick();
    chk("x7_busy_c2", {31'b0, rs1_busy_o}, 32'h1);
    tick();
    reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x7_c3_busy", {31'b0, rs1_busy_o}, 32'h0);
    chk("x7_c3_rdata", rs1_rdata_o, 32'h55);
`else
    chk("x7_c3_busy", {31'b0, rs1_busy_o}, 32'h1);
    chk("x7_c3_rdata", rs1_rdata_o, 32'h0);
`endif
    tick();
    reg_we_i = 1'b0;
    #1;
    chk("x7_c4_busy", {31'b0, rs1_busy_o}, 32'h0);
    chk("x7_c4_rdata", rs1_rdata_o, 32'h55);

    // simultaneous set and clear on x9: set wins
    pend_set_i = 1'b1; pend_addr_i = 5'd9;
    tick();
    reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'h1;
    tick();
    reg_we_i = 1'b0; pend_set_i = 1'b0;
    rs1_raddr_i = 5'd9;
    #1;
    chk("x9_rdata", rs1_rdata_o, 32'h1);
    chk("x9_still_busy", {31'b0, rs1_busy_o}, 32'h1);

    // different addresses: clear x9 and set x10 together
    reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'h2;
    pend_set_i = 1'b1; pend_addr_i = 5'd10;
    tick();
    reg_we_i = 1'b0; pend_set_i = 1'b0;
    rs2_re_i = 1'b1; rs2_raddr_i = 5'd10;
    #1;
    chk("x9_cleared_busy", {31'b0, rs1_busy_o}, 32'h0);
    chk("x9_rdata2", rs1_rdata_o, 32'h2);
    chk("x10_busy", {31'b0, rs2_busy_o}, 32'h1);

    // same-cycle read/write of pending x4
    reg_we_i = 1'b1; reg_waddr_i = 5'd4; reg_wdata_i = 32'h11;
    tick();
    reg_we_i = 1'b0;
    pend_set_i = 1'b1; pend_addr_i = 5'd4;
    tick();
    pend_set_i = 1'b0;
    reg_we_i = 1'b1; reg_waddr_i = 5'd4; reg_wdata_i = 32'h77;
    rs1_raddr_i = 5'd4; rs2_raddr_i = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x4_rs1_rdata", rs1_rdata_o, 32'h77);
    chk("x4_rs1_busy", {31'b0, rs1_busy_o}, 32'h0);
    chk("x4_rs2_rdata", rs2_rdata_o, 32'h77);
`else
    chk("x4_rs1_rdata", rs1_rdata_o, 32'h11);
    chk("x4_rs1_busy", {31'b0, rs1_busy_o}, 32'h1);
    chk("x4_rs2_rdata", rs2_rdata_o, 32'h11);
`endif
    tick();
    reg_we_i = 1'b0;
    #1;
    chk("x4_next_rdata", rs1_rdata_o, 32'h77);
    chk("x4_next_busy", {31'b0, rs1_busy_o}, 32'h0);

    // reset mid-operation discards write and set to x2
    pend_set_i = 1'b1; pend_addr_i = 5'd2;
    reg_we_i = 1'b1; reg_waddr_i = 5'd2; reg_wdata_i = 32'hCAFE;
    rs1_raddr_i = 5'd2; rs2_raddr_i = 5'd10;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_mid_rdata", rs1_rdata_o, 32'h0);
    chk("rst_mid_busy1", {31'b0, rs1_busy_o}, 32'h0);
    chk("rst_mid_busy2", {31'b0, rs2_busy_o}, 32'h0);
    tick();
    rst_i = 1'b0;
    pend_set_i = 1'b0; reg_we_i = 1'b0;
    #1;
    chk("x2_after_rst", rs1_rdata_o, 32'h0);
    chk("x2_busy_after_rst", {31'b0, rs1_busy_o}, 32'h0);
    chk("x10_busy_after_rst", {31'b0, rs2_busy_o}, 32'h0);
    rs1_raddr_i = 5'd3;
    #1;
    chk("x3_after_rst", rs1_rdata_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
